// File: rtl/obi_arb_pkg.sv
// Shared types and default widths for the two-to-one OBI memory arbiter.
package obi_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_e;

    localparam int unsigned DEF_ADDR_WIDTH      = 32;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    endfunction

endpackage

// File: rtl/obi_arb_fifo.sv
// Routing FIFO remembering which slave port issued each in-flight transfer.
module obi_arb_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [WIDTH-1:0]          head_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra bit so equal low bits distinguish full from empty.
    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = push_ok ? (wptr_q + ONE) : wptr_q;
        rptr_d = pop_ok  ? (rptr_q + ONE) : rptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin merge of instruction and data OBI ports onto one master port,
// with in-order response routing back to the issuing port.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [1:0]                          s_req_i,
    output logic [1:0]                          s_gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0]          s_addr_i,
    input  logic [1:0]                          s_we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]        s_be_i,
    input  logic [1:0][DATA_WIDTH-1:0]          s_wdata_i,
    output logic [1:0]                          s_rvalid_o,
    output logic [DATA_WIDTH-1:0]               s_rdata_o,
    output logic                                m_req_o,
    input  logic                                m_gnt_i,
    output logic [ADDR_WIDTH-1:0]               m_addr_o,
    output logic                                m_we_o,
    output logic [DATA_WIDTH/8-1:0]             m_be_o,
    output logic [DATA_WIDTH-1:0]               m_wdata_o,
    input  logic                                m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               m_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
    output logic                                err_o
);
    port_id_e   cand;
    port_id_e   last_q, last_d;
    logic       cand_valid;
    logic       sel;
    logic       handshake;
    logic       pop;
    logic       err_q, err_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic [0:0] head;

    always_comb begin
        cand = PORT_INSTR;
        unique case (s_req_i)
            2'b01:   cand = PORT_INSTR;
            2'b10:   cand = PORT_DATA;
            2'b11:   cand = other_port(last_q);
            default: cand = PORT_INSTR;
        endcase
    end

    assign cand_valid = |s_req_i;
    assign sel        = (cand == PORT_DATA);
    // Full is taken from the registered count only, so rvalid never reaches m_req_o.
    assign m_req_o    = cand_valid && !fifo_full;
    assign handshake  = m_req_o && m_gnt_i;
    assign pop        = m_rvalid_i && !fifo_empty;

    always_comb begin
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        if (cand_valid) begin
            m_addr_o  = s_addr_i[sel];
            m_we_o    = s_we_i[sel];
            m_be_o    = s_be_i[sel];
            m_wdata_o = s_wdata_i[sel];
        end
    end

    always_comb begin
        s_gnt_o           = '0;
        s_gnt_o[sel]      = handshake;
        s_rvalid_o        = '0;
        s_rvalid_o[head]  = pop;
        s_rdata_o         = pop ? m_rdata_i : '0;
    end

    always_comb begin
        last_d = handshake ? cand : last_q;
        err_d  = err_q | (m_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= PORT_DATA;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

    obi_arb_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .wdata_i (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed and randomized bench for obi_mem_arbiter against a queue-based reference model.
module tb_obi_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                   clk;
    logic                   rst_ni;
    logic [1:0]             s_req_i;
    logic [1:0]             s_gnt_o;
    logic [1:0][AW-1:0]     s_addr_i;
    logic [1:0]             s_we_i;
    logic [1:0][DW/8-1:0]   s_be_i;
    logic [1:0][DW-1:0]     s_wdata_i;
    logic [1:0]             s_rvalid_o;
    logic [DW-1:0]          s_rdata_o;
    logic                   m_req_o;
    logic                   m_gnt_i;
    logic [AW-1:0]          m_addr_o;
    logic                   m_we_o;
    logic [DW/8-1:0]        m_be_o;
    logic [DW-1:0]          m_wdata_o;
    logic                   m_rvalid_i;
    logic [DW-1:0]          m_rdata_i;
    logic [$clog2(MO):0]    outstanding_o;
    logic                   err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: issue-order queue of port ids, last winner, sticky error.
    int q[$];
    int last;
    bit merr;

    obi_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .s_req_i       (s_req_i),
        .s_gnt_o       (s_gnt_o),
        .s_addr_i      (s_addr_i),
        .s_we_i        (s_we_i),
        .s_be_i        (s_be_i),
        .s_wdata_i     (s_wdata_i),
        .s_rvalid_o    (s_rvalid_o),
        .s_rdata_o     (s_rdata_o),
        .m_req_o       (m_req_o),
        .m_gnt_i       (m_gnt_i),
        .m_addr_o      (m_addr_o),
        .m_we_o        (m_we_o),
        .m_be_o        (m_be_o),
        .m_wdata_o     (m_wdata_o),
        .m_rvalid_i    (m_rvalid_i),
        .m_rdata_i     (m_rdata_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 2; i++) begin
            s_addr_i[i]  = $urandom;
            s_we_i[i]    = (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_be_i[i]    = 4'($urandom_range(0, 15));
            s_wdata_i[i] = $urandom;
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        int cand;
        bit cvalid, mreq, hs, pop;
        s_req_i    = req;
        m_gnt_i    = gnt;
        m_rvalid_i = rv;
        m_rdata_i  = rd;
        #1;
        cvalid = (req != 2'b00);
        if (req == 2'b11)      cand = 1 - last;
        else if (req == 2'b10) cand = 1;
        else                   cand = 0;
        mreq = cvalid && (q.size() < MO);
        hs   = mreq && gnt;
        pop  = rv && (q.size() > 0);
        chk("m_req", m_req_o, mreq);
        chk("s_gnt", s_gnt_o, hs ? (1 << cand) : 0);
        if (cvalid) begin
            chk("m_addr",  m_addr_o,  s_addr_i[cand]);
            chk("m_we",    m_we_o,    s_we_i[cand]);
            chk("m_be",    m_be_o,    s_be_i[cand]);
            chk("m_wdata", m_wdata_o, s_wdata_i[cand]);
        end
        chk("s_rvalid", s_rvalid_o, pop ? (1 << q[0]) : 0);
        if (pop) chk("s_rdata", s_rdata_o, rd);
        chk("outstanding", outstanding_o, q.size());
        chk("err", err_o, merr);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (rv && !pop) merr = 1'b1;
        if (hs) begin
            q.push_back(cand);
            last = cand;
        end
        @(negedge clk);
    endtask

    // Asserted away from any clock edge, so cleared state shows before the next posedge.
    task automatic do_reset();
        rst_ni     = 1'b0;
        s_req_i    = 2'b00;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'hA5A5_5A5A;
        #1;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err",         err_o,         0);
        chk("rst_m_req",       m_req_o,       0);
        chk("rst_s_gnt",       s_gnt_o,       0);
        chk("rst_s_rvalid",    s_rvalid_o,    0);
        chk("rst_s_rdata",     s_rdata_o,     0);
        chk("rst_m_addr",      m_addr_o,      0);
        chk("rst_m_wdata",     m_wdata_o,     0);
        q.delete();
        last = 1;
        merr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni     = 1'b1;
        s_req_i    = 2'b00;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        rand_payload();
        @(negedge clk);
        do_reset();

        // Single read from the data port.
        rand_payload();
        s_addr_i[1] = 32'h100;
        s_we_i[1]   = 1'b0;
        step(2'b10, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(2'b00, 1'b1, 1'b0, 32'h0);
        chk("single_done", outstanding_o, 0);

        // Tie after reset alternates instr/data until full.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            step(2'b11, 1'b1, 1'b0, 32'h0);
        end
        chk("full_count", outstanding_o, MO);
        step(2'b11, 1'b1, 1'b1, $urandom);
        step(2'b11, 1'b1, 1'b0, 32'h0);

        // Drain two, then push and pop together at count 2.
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b1, $urandom);
        rand_payload();
        step(2'b01, 1'b1, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("pushpop_count", outstanding_o, 2);
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b1, $urandom);

        // Spurious response with nothing in flight; error is sticky.
        step(2'b00, 1'b0, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("err_sticky", err_o, 1);
        do_reset();

        // Random interleaved traffic, responses only while something is in flight.
        for (int i = 0; i < 60; i++) begin
            rand_payload();
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
        end
        for (int i = 0; i < MO; i++) begin
            if (q.size() > 0) step(2'b00, 1'b0, 1'b1, $urandom);
        end
        chk("random_drained", outstanding_o, 0);

        // Reset with three outstanding, then stale response after reset.
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            step(2'b01, 1'b1, 1'b0, 32'h0);
        end
        chk("pre_reset_count", outstanding_o, 3);
        do_reset();
        rand_payload();
        step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("stale_err", err_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one OBI arbiter between `gpgpu_top` and a single-port memory. It merges the instruction-fetch and data-access request streams onto one OBI master port. Arbitration is round-robin, and each response is routed back to the port that issued the request. It sits directly downstream of the `gpgpu_top` memory ports, so a single-port RAM or an external bus can replace the dual-port RAM model.

## Interface
- `ADDR_WIDTH`, default 32: address width, all ports.
- `DATA_WIDTH`, default 32: data width. Byte-enable width is `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, default 4: accepted but unanswered transactions allowed. Power of two, ≥2.
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `s_req_i[1:0]`  in  2  request per slave port; 0 = instr, 1 = data.
- `s_gnt_o[1:0]`  out  2  grant per slave port.
- `s_addr_i[1:0]`  in  2×ADDR_WIDTH  byte address.
- `s_we_i[1:0]`  in  2  write enable; instr port tied 0 by the integrator.
- `s_be_i[1:0]`  in  2×DATA_WIDTH/8  byte enables.
- `s_wdata_i[1:0]`  in  2×DATA_WIDTH  write data.
- `s_rvalid_o[1:0]`  out  2  response valid per slave port.
- `s_rdata_o`  out  DATA_WIDTH  response data, shared; qualified by `s_rvalid_o`.
- `m_req_o`  out  1  master request.
- `m_gnt_i`  in  1  master grant.
- `m_addr_o`  out  ADDR_WIDTH  master address.
- `m_we_o`  out  1  master write enable.
- `m_be_o`  out  DATA_WIDTH/8  master byte enables.
- `m_wdata_o`  out  DATA_WIDTH  master write data.
- `m_rvalid_i`  in  1  master response valid.
- `m_rdata_i`  in  DATA_WIDTH  master response data.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING)+1  in-flight transaction count.
- `err_o`  out  1  sticky protocol error: `m_rvalid_i` received with nothing in flight.

## Operation
**Protocol**
- OBI address phase: a transfer occurs in any cycle with req && gnt.
- Slaves hold `req` and payload stable until granted.
- The master returns exactly one `m_rvalid_i` per accepted transfer, in order. Writes also get an rvalid.

**Arbitration**
- Candidate = requesting port. If both request, the candidate is the port not in `last_q`.
- `m_req_o` = candidate exists && !full.
- `m_addr_o`, `m_we_o`, `m_be_o` and `m_wdata_o` are muxed combinationally from the candidate.
- `s_gnt_o[cand]` = `m_gnt_i` && `m_req_o`. The other grant is 0.
- `last_q` updates to the candidate only on a master handshake.
- `last_q` resets to 1, so port 0 (instr) wins the first tie.

**Routing FIFO**
- On each handshake, push the candidate id.
- On `m_rvalid_i` with FIFO non-empty, pop the head.
- Pop drives `s_rvalid_o[head]` = 1 and `s_rdata_o` = `m_rdata_i`, combinationally, in the same cycle.

**Boundary conditions**
- Full (`outstanding` = MAX_OUTSTANDING): `m_req_o` = 0, even if a pop happens that cycle. There is no rvalid→req combinational path.
- Push and pop in the same cycle: count unchanged.
- `m_rvalid_i` while empty: no `s_rvalid_o`, set `err_o`. Only reset clears `err_o`.
- A request withdrawn before grant is a slave protocol violation and is not checked.
- Reset mid-operation: FIFO, count, `last_q` and `err_o` clear immediately. Responses for pre-reset transfers arriving after reset set `err_o`.

## Timing
- Reset values: `outstanding_o` = 0, `err_o` = 0, `last_q` = 1.
- In reset, all combinational outputs are 0 provided `s_req_i` = 0 and `m_rvalid_i` = 0.
- Request path (req→gnt) is fully combinational: 0-cycle arbitration latency.
- Response path is combinational: 0 added latency.
- `outstanding_o` is registered and reflects handshakes/pops from the previous cycle.
- Throughput: one transfer per cycle while not full. Alternating ports when both request continuously.

## Structure
- Package `obi_arb_pkg`:
  - typedef `port_id_e` (PORT_INSTR = 0, PORT_DATA = 1).
  - default width localparams.
- Sub-module `obi_arb_fifo`: synchronous FIFO, parameters WIDTH=1 and DEPTH=MAX_OUTSTANDING.
  - Pointers wrap modulo DEPTH, with an extra count bit.
  - Outputs `full`, `empty`, `head`.
  - Async active-low reset.

## Test plan
- Single read: data port requests addr 0x100 with `m_gnt_i`=1 → `s_gnt_o`=2'b10 the same cycle. Master returns `rvalid` with 0xDEADBEEF two cycles later → `s_rvalid_o`=2'b10 and `s_rdata_o`=0xDEADBEEF. `outstanding_o` goes 0→1→0.
- Tie after reset: both ports request continuously with `m_gnt_i`=1 → grant sequence instr, data, instr, data. Responses return to ports in issue order.
- Full stall: `m_gnt_i`=1, no rvalid, MAX_OUTSTANDING=4 → four grants, then `m_req_o`=0. One rvalid arrives → `m_req_o`=1 the following cycle, not the same cycle.
- Simultaneous push/pop at count 2 → count stays 2. Routing ids stay correct over 20 random interleaved transfers, checked by a scoreboard.
- Spurious rvalid with count 0 → `err_o`=1, no `s_rvalid_o`. `err_o` stays 1 until `rst_ni` pulses low.
- Reset asserted with 3 outstanding → `outstanding_o`=0 asynchronously. A post-reset first tie grants instr.
